// File: rtl/if_sync_fifo_pkg.sv
// Shared constants for the first-word-fall-through FIFO: output buffer
// depth and the read latency of the backing RAM.
package if_sync_fifo_pkg;

  // Words the output buffer can hold. The read-issue throttle keeps the
  // buffer plus in-flight RAM reads within this bound.
  localparam int OBUF_DEPTH = 4;

  // Edges from RAM read issue to valid RAM output (address reg + output reg).
  localparam int RD_LAT = 2;

  // Index width of the output buffer.
  localparam int OBUF_AW = $clog2(OBUF_DEPTH);

endpackage

// File: rtl/if_sdp_ram_l.sv
// Simple dual-port RAM: one write port, one read port, each with its own
// clock. The read port registers the address-stage data and, with OR="TRUE",
// adds an output register, giving a two-edge read latency.
module if_sdp_ram_l #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter     OR = "TRUE",
  parameter     IF = ""
) (
  input  logic          A_Ck,
  input  logic          A_We,
  input  logic [AW-1:0] A_Addr,
  input  logic [DW-1:0] A_Dat,
  input  logic          B_Ck,
  input  logic          B_Ce,
  input  logic [AW-1:0] B_Addr,
  output logic [DW-1:0] B_Dat
);

  // NOTE: the storage array has no reset; clearing a RAM would force it into
  // flops. Readers must only trust words they have written.
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] b_q1;

  // Write port: store the word on a write strobe.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // its inputs as they were before the edge.
  always_ff @(posedge A_Ck) begin
    if (A_We) begin
      mem[A_Addr] <= A_Dat;
    end
  end

  // Read port, first stage: registered array read.
  always_ff @(posedge B_Ck) begin
    if (B_Ce) begin
      b_q1 <= mem[B_Addr];
    end
  end

  generate
    if (OR == "TRUE") begin : g_oreg
      logic [DW-1:0] b_q2;

      // Read port, output register: second edge of read latency.
      always_ff @(posedge B_Ck) begin
        if (B_Ce) begin
          b_q2 <= b_q1;
        end
      end

      assign B_Dat = b_q2;
    end else begin : g_no_oreg
      assign B_Dat = b_q1;
    end

    // A preload file is a vendor-flow feature; this model always powers up
    // with undefined contents whatever IF names.
    if (IF != "") begin : g_preload_ignored
    end
  endgenerate

endmodule

// File: rtl/if_sync_fifo.sv
// First-word-fall-through FIFO built on a two-cycle-latency RAM. Writes land
// in the RAM; reads are pre-issued into a small output buffer so the head word
// is presented combinationally from flops and a pop every cycle is sustained.
module if_sync_fifo
  import if_sync_fifo_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          Ck,
  input  logic          Rst,
  input  logic          Wr_Vld,
  output logic          Wr_Rdy,
  input  logic [DW-1:0] Wr_Dat,
  output logic          Rd_Vld,
  input  logic          Rd_Rdy,
  output logic [DW-1:0] Rd_Dat,
  output logic [AW+1:0] Cnt,
  output logic          Full,
  output logic          Empty
);

  // RAM depth as an (AW+1)-bit occupancy value.
  localparam logic [AW:0] RAM_WORDS = {1'b1, {AW{1'b0}}};
  // Width wide enough to sum the buffer count and every in-flight read.
  localparam int          CLAIM_W   = OBUF_AW + 2;

  // RAM bookkeeping.
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        ram_cnt;
  logic [DW-1:0]      ram_q;

  // v_pipe[0] is a read one edge old, v_pipe[RD_LAT-1] marks ram_q valid.
  logic [RD_LAT-1:0]  v_pipe;

  // Output buffer: small circular queue in front of Rd_Dat.
  logic [DW-1:0]      obuf_mem [OBUF_DEPTH];
  logic [OBUF_AW-1:0] obuf_wr;
  logic [OBUF_AW-1:0] obuf_rd;
  logic [OBUF_AW:0]   obuf_cnt;

  // Total words held anywhere in the FIFO.
  logic [AW+1:0]      cnt;

  logic               wr_fire;
  logic               rd_fire;
  logic               rd_issue;
  logic               capture;
  logic [CLAIM_W-1:0] obuf_claim;

  // Write readiness depends on registered RAM occupancy only, so a read
  // issued this cycle frees a slot no earlier than the next cycle.
  assign Wr_Rdy  = (ram_cnt < RAM_WORDS);
  assign wr_fire = Wr_Vld & Wr_Rdy;

  assign Rd_Vld  = (obuf_cnt != '0);
  assign Rd_Dat  = obuf_mem[obuf_rd];
  assign rd_fire = Rd_Vld & Rd_Rdy;

  assign capture = v_pipe[RD_LAT-1];

  assign Cnt     = cnt;
  assign Full    = (ram_cnt == RAM_WORDS);
  assign Empty   = (cnt == '0);

  // Read issue: a RAM word exists and the buffer has room for every read
  // already in flight plus this one, so the buffer can never overflow.
  always_comb begin
    // NOTE: every always_comb output gets a value before any condition so no
    // path can fall through and infer a latch.
    obuf_claim = CLAIM_W'(obuf_cnt);
    rd_issue   = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      obuf_claim = obuf_claim + CLAIM_W'(v_pipe[i]);
    end
    if ((ram_cnt != '0) && (obuf_claim < CLAIM_W'(OBUF_DEPTH))) begin
      rd_issue = 1'b1;
    end
  end

  // RAM pointers and occupancy: +1 on write, -1 on read issue.
  always_ff @(posedge Ck or posedge Rst) begin
    if (Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_fire, rd_issue})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

  // In-flight read tracker: shifts alongside the RAM's read pipeline.
  always_ff @(posedge Ck or posedge Rst) begin
    if (Rst) begin
      v_pipe <= '0;
    end else begin
      v_pipe <= {v_pipe[RD_LAT-2:0], rd_issue};
    end
  end

  // Output buffer: capture RAM output when valid, advance head on pop.
  // Entries are cleared on reset so Rd_Dat reads zero while empty.
  always_ff @(posedge Ck or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        obuf_mem[i] <= '0;
      end
      obuf_wr  <= '0;
      obuf_rd  <= '0;
      obuf_cnt <= '0;
    end else begin
      if (capture) begin
        obuf_mem[obuf_wr] <= ram_q;
        obuf_wr           <= obuf_wr + 1'b1;
      end
      if (rd_fire) begin
        obuf_rd <= obuf_rd + 1'b1;
      end
      unique case ({capture, rd_fire})
        2'b10:   obuf_cnt <= obuf_cnt + 1'b1;
        2'b01:   obuf_cnt <= obuf_cnt - 1'b1;
        default: obuf_cnt <= obuf_cnt;
      endcase
    end
  end

  // Total occupancy: +1 on accepted write, -1 on pop.
  always_ff @(posedge Ck or posedge Rst) begin
    if (Rst) begin
      cnt <= '0;
    end else begin
      unique case ({wr_fire, rd_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Backing store: read port always enabled, address is the read pointer.
  if_sdp_ram_l #(
    .AW (AW),
    .DW (DW),
    .OR ("TRUE"),
    .IF ("")
  ) u_ram (
    .A_Ck   (Ck),
    .A_We   (wr_fire),
    .A_Addr (wr_ptr),
    .A_Dat  (Wr_Dat),
    .B_Ck   (Ck),
    .B_Ce   (1'b1),
    .B_Addr (rd_ptr),
    .B_Dat  (ram_q)
  );

endmodule

// File: tb/tb_if_sync_fifo.sv
// Scoreboard bench for if_sync_fifo. The driver pushes each word it expects
// to be accepted; the monitor pops and compares on every handshake.
module tb_if_sync_fifo;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          Ck = 1'b0;
  logic          Rst = 1'b0;
  logic          Wr_Vld = 1'b0;
  logic          Wr_Rdy;
  logic [DW-1:0] Wr_Dat = '0;
  logic          Rd_Vld;
  logic          Rd_Rdy = 1'b0;
  logic [DW-1:0] Rd_Dat;
  logic [AW+1:0] Cnt;
  logic          Full;
  logic          Empty;

  if_sync_fifo #(.AW(AW), .DW(DW)) dut (
    .Ck     (Ck),
    .Rst    (Rst),
    .Wr_Vld (Wr_Vld),
    .Wr_Rdy (Wr_Rdy),
    .Wr_Dat (Wr_Dat),
    .Rd_Vld (Rd_Vld),
    .Rd_Rdy (Rd_Rdy),
    .Rd_Dat (Rd_Dat),
    .Cnt    (Cnt),
    .Full   (Full),
    .Empty  (Empty)
  );

  always #5 Ck = ~Ck;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q [$];
  int            model_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: runs on the falling edge, when inputs and outputs are settled
  // for the coming rising edge.
  always @(negedge Ck) begin
    if (Rst) begin
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      check("cnt_track", 32'(Cnt), 32'(model_cnt));
      check("empty_track", 32'(Empty), 32'(model_cnt == 0));
      if (prev_stall) begin
        check("stall_vld", 32'(Rd_Vld), 32'd1);
        check("stall_dat", 32'(Rd_Dat), 32'(prev_dat));
      end
      if (Rd_Vld && Rd_Rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no word at %0t", Rd_Dat, $time);
        end else begin
          check("rd_dat", 32'(Rd_Dat), 32'(exp_q.pop_front()));
        end
      end
      model_cnt  = model_cnt + int'(Wr_Vld && Wr_Rdy) - int'(Rd_Vld && Rd_Rdy);
      prev_stall = Rd_Vld && !Rd_Rdy;
      prev_dat   = Rd_Dat;
    end
  end

  task automatic tick();
    @(posedge Ck);
    #1;
  endtask

  // Assert reset mid-cycle, check outputs immediately, release before an edge.
  task automatic do_reset();
    Rst    = 1'b1;
    Wr_Vld = 1'b0;
    Rd_Rdy = 1'b0;
    exp_q.delete();
    #1;
    check("rst_wr_rdy", 32'(Wr_Rdy), 32'd1);
    check("rst_rd_vld", 32'(Rd_Vld), 32'd0);
    check("rst_full",   32'(Full),   32'd0);
    check("rst_empty",  32'(Empty),  32'd1);
    check("rst_cnt",    32'(Cnt),    32'd0);
    check("rst_rd_dat", 32'(Rd_Dat), 32'd0);
    @(negedge Ck);
    #1;
    Rst = 1'b0;
    tick();
  endtask

  // Present a word for one cycle; exp_acc is the hand-derived acceptance.
  task automatic offer(input string name, input logic [DW-1:0] d, input bit exp_acc);
    Wr_Vld = 1'b1;
    Wr_Dat = d;
    check(name, 32'(Wr_Rdy), 32'(exp_acc));
    if (exp_acc) exp_q.push_back(d);
    tick();
  endtask

  // Pop until empty within a cycle budget.
  task automatic drain(input string name);
    Wr_Vld = 1'b0;
    Rd_Rdy = 1'b1;
    for (int i = 0; i < 64 && !Empty; i++) tick();
    check({name, "_empty"}, 32'(Empty), 32'd1);
    check({name, "_sb"}, 32'(exp_q.size()), 32'd0);
  endtask

  int wr_pct [10] = '{50, 90, 20, 70, 95, 30, 60, 85, 10, 50};
  int rd_pct [10] = '{50, 20, 90, 70, 10, 95, 60, 40, 80, 50};

  initial begin
    logic [DW-1:0] d;
    #2;
    do_reset();

    // Single word: Rd_Vld rises on the 4th edge counting the accept edge.
    Rd_Rdy = 1'b1;
    offer("a5_wr_rdy", 8'hA5, 1'b1);
    Wr_Vld = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      check("a5_lat_early", 32'(Rd_Vld), 32'd0);
      tick();
    end
    check("a5_lat_vld", 32'(Rd_Vld), 32'd1);
    check("a5_dat", 32'(Rd_Dat), 32'hA5);
    tick();
    check("a5_empty", 32'(Empty), 32'd1);

    // Fill with no pops: 16 in RAM + 4 in the output buffer, 20..23 refused.
    do_reset();
    for (int i = 0; i < 24; i++) offer("fill_wr_rdy", DW'(i), i < 20);
    Wr_Vld = 1'b0;
    check("fill_cnt",    32'(Cnt),    32'd20);
    check("fill_full",   32'(Full),   32'd1);
    check("fill_wr_rdy", 32'(Wr_Rdy), 32'd0);
    check("fill_rd_vld", 32'(Rd_Vld), 32'd1);
    check("fill_head",   32'(Rd_Dat), 32'd0);

    // Stream from full: the write port stays closed for two pops until the
    // first refill read frees a RAM slot, so Cnt settles two below full and
    // then holds while one word enters and one leaves per cycle.
    Rd_Rdy = 1'b1;
    d = 8'd20;
    for (int k = 0; k < 40; k++) begin
      Wr_Vld = 1'b1;
      Wr_Dat = d;
      check("stream_wr_rdy", 32'(Wr_Rdy), 32'(k >= 2));
      if (k >= 2) begin
        exp_q.push_back(d);
        d = d + 8'd1;
      end
      tick();
      check("stream_cnt", 32'(Cnt), (k == 0) ? 32'd19 : 32'd18);
      check("stream_rd_vld", 32'(Rd_Vld), 32'd1);
    end
    drain("stream");

    // Random traffic in phases of different write/read pressure.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      Wr_Vld = ($urandom_range(0, 99) < wr_pct[c / 1000]);
      Rd_Rdy = ($urandom_range(0, 99) < rd_pct[c / 1000]);
      Wr_Dat = DW'($urandom);
      if (Wr_Vld && Wr_Rdy) exp_q.push_back(Wr_Dat);
      tick();
    end
    drain("random");

    // Reset with 7 words held and two RAM reads in flight.
    do_reset();
    for (int i = 0; i < 7; i++) offer("mid_wr_rdy", 8'h10 + DW'(i), 1'b1);
    Rd_Rdy = 1'b1;
    offer("mid_wr_rdy", 8'h17, 1'b1);
    offer("mid_wr_rdy", 8'h18, 1'b1);
    Wr_Vld = 1'b0;
    Rd_Rdy = 1'b0;
    tick();
    check("mid_cnt", 32'(Cnt), 32'd7);
    do_reset();
    Rd_Rdy = 1'b1;
    offer("post_wr_rdy", 8'h3C, 1'b1);
    Wr_Vld = 1'b0;
    for (int i = 0; i < 10 && !Rd_Vld; i++) tick();
    check("post_rd_vld", 32'(Rd_Vld), 32'd1);
    check("post_first", 32'(Rd_Dat), 32'h3C);
    drain("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
